// File: rtl/sat_search_controller.sv
// -----------------------------------------------------------------------------
// sat_search_controller
//
// Walks every NVARS-bit assignment from 0 up to all-ones. Each candidate is
// driven onto the external clause evaluator and held for STEP_DIV cycles.
// The returned sat flag is sampled on the last cycle of that dwell. The block
// then latches the solution, declares the space exhausted, or steps to the
// next candidate. It also owns the board status: the RGB colour code and the
// LEDs that mirror the candidate.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      1-cycle pulse: start a search from candidate 0 (ignored in EVAL)
//   abort      1-cycle pulse: return to IDLE from any state (beats start)
//   sat        evaluator result for the candidate currently driven
//   candidate  assignment presented to the evaluator
//   solution   latched satisfying assignment, valid while found=1
//   LED        registered mirror of candidate
//   RGB        001 red (idle/searching), 010 green (found), 100 blue (none)
//   busy       high while searching
//   done       high once the search has ended (found or exhausted)
//   found      high when a satisfying assignment was latched
// -----------------------------------------------------------------------------
module sat_search_controller #(
   parameter int NVARS    = 3,
   parameter int STEP_DIV = 4   // dwell in cycles, must be >= 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             sat,
   output logic [NVARS-1:0] candidate,
   output logic [NVARS-1:0] solution,
   output logic [NVARS-1:0] LED,
   output logic [2:0]       RGB,
   output logic             busy,
   output logic             done,
   output logic             found
);

   localparam int              CW       = $clog2(STEP_DIV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STEP_DIV - 1);
   localparam logic [2:0]      RGB_RED   = 3'b001;
   localparam logic [2:0]      RGB_GREEN = 3'b010;
   localparam logic [2:0]      RGB_BLUE  = 3'b100;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      FOUND,
      NONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Single registered FSM. Every output is a flop, so each branch below sets
   // exactly the outputs that change on that edge; the rest hold their value.
   // NOTE: all state here is assigned with <= so every flop samples the values
   // from before the edge; mixing in = would make results depend on statement
   // order and break the one-cycle timing of the search.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         candidate <= '0;
         solution  <= '0;
         LED       <= '0;
         RGB       <= RGB_RED;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         cnt       <= '0;
      end else if (abort) begin
         // abort takes priority over start; solution is deliberately kept
         state     <= IDLE;
         candidate <= '0;
         LED       <= '0;
         RGB       <= RGB_RED;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= EVAL;
                  candidate <= '0;
                  LED       <= '0;
                  cnt       <= '0;
                  busy      <= 1'b1;
               end
            end

            EVAL: begin
               // sat is only meaningful once the evaluator has settled, i.e.
               // on the final cycle of the dwell; earlier values are ignored.
               if (cnt == CNT_LAST) begin
                  if (sat) begin
                     state    <= FOUND;
                     solution <= candidate;
                     found    <= 1'b1;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     RGB      <= RGB_GREEN;
                  end else if (&candidate) begin
                     // last candidate rejected: hold at all-ones, never wrap
                     state <= NONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     RGB   <= RGB_BLUE;
                  end else begin
                     candidate <= candidate + 1'b1;
                     LED       <= candidate + 1'b1;
                     cnt       <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            FOUND, NONE: begin
               if (start) begin
                  state     <= EVAL;
                  candidate <= '0;
                  LED       <= '0;
                  solution  <= '0;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  found     <= 1'b0;
                  RGB       <= RGB_RED;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sat_search_controller.sv
// -----------------------------------------------------------------------------
// tb_sat_search_controller
//
// Directed scenarios for sat_search_controller (NVARS=3, STEP_DIV=4). The
// stimulus process queues the expected output vector for a given clock edge
// index; a separate monitor samples the DUT on the falling edge of that cycle,
// pops the entry and compares.
// -----------------------------------------------------------------------------
module tb_sat_search_controller;

   localparam int NV = 3;
   localparam int SD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          sat;
   logic [NV-1:0] candidate;
   logic [NV-1:0] solution;
   logic [NV-1:0] led;
   logic [2:0]    rgb;
   logic          busy;
   logic          done;
   logic          found;

   // evaluator model: 0 = never satisfied, 1 = satisfied at target, 2 = manual
   int            mode;
   logic [NV-1:0] target;
   logic          sat_manual;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   sat_search_controller #(.NVARS(NV), .STEP_DIV(SD)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .sat       (sat),
      .candidate (candidate),
      .solution  (solution),
      .LED       (led),
      .RGB       (rgb),
      .busy      (busy),
      .done      (done),
      .found     (found)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign sat = (mode == 1) ? (candidate == target) :
                (mode == 2) ? sat_manual : 1'b0;

   // packed view: {candidate, solution, LED, RGB, busy, done, found}
   typedef struct {
      int          at;
      string       name;
      logic [14:0] v;
   } exp_t;

   exp_t q[$];

   function automatic logic [14:0] pk(input logic [2:0] c, input logic [2:0] s,
                                      input logic [2:0] l, input logic [2:0] r,
                                      input logic b, input logic d, input logic f);
      return {c, s, l, r, b, d, f};
   endfunction

   function automatic logic [14:0] idle_v(input logic [2:0] s);
      return pk(3'd0, s, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [14:0] eval_v(input int c, input logic [2:0] s);
      logic [2:0] cv;
      cv = 3'(c);
      return pk(cv, s, cv, 3'b001, 1'b1, 1'b0, 1'b0);
   endfunction

   function automatic logic [14:0] found_v(input logic [2:0] c);
      return pk(c, c, c, 3'b010, 1'b0, 1'b1, 1'b1);
   endfunction

   function automatic logic [14:0] none_v();
      return pk(3'b111, 3'd0, 3'b111, 3'b100, 1'b0, 1'b1, 1'b0);
   endfunction

   task automatic expect_at(input int at, input string name, input logic [14:0] v);
      exp_t e;
      e.at   = at;
      e.name = name;
      e.v    = v;
      q.push_back(e);
   endtask

   task automatic check(input string name, input int at, input logic [14:0] act,
                        input logic [14:0] exp_v);
      checks++;
      if (at != cyc || act !== exp_v) begin
         errors++;
         $display("FAIL %s edge %0d (sampled at %0d): got %b required %b",
                  name, at, cyc, act, exp_v);
      end
   endtask

   // monitor: compare every expectation that falls due in this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            check(e.name, e.at, {candidate, solution, led, rgb, busy, done, found}, e.v);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      int s;
      reset      = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      mode       = 0;
      target     = '0;
      sat_manual = 1'b0;

      // reset held for three cycles, then idle
      expect_at(2, "reset_state", idle_v(3'd0));
      repeat (3) tick();
      reset = 1'b0;
      expect_at(cyc + 2, "idle_after_reset", idle_v(3'd0));
      tick();
      tick();

      // single solution at 101: dwell of 4 per candidate, found at edge 24
      mode   = 1;
      target = 3'b101;
      s      = cyc + 1;
      for (int n = 0; n < 24; n++) expect_at(s + n, "dwell", eval_v(n / SD, 3'd0));
      expect_at(s + 24, "found_101", found_v(3'b101));
      expect_at(s + 27, "found_hold", found_v(3'b101));
      pulse_start();
      wait_until(s + 28);

      // restart from FOUND clears found/done/solution; unsatisfiable run
      mode = 0;
      s    = cyc + 1;
      for (int n = 0; n < 32; n++) expect_at(s + n, "unsat_walk", eval_v(n / SD, 3'd0));
      expect_at(s + 32, "none_at_32", none_v());
      expect_at(s + 36, "none_no_wrap", none_v());
      pulse_start();
      wait_until(s + 37);

      // abort from NONE
      s = cyc + 1;
      expect_at(s, "abort_from_none", idle_v(3'd0));
      pulse_abort();
      wait_until(s + 1);

      // sat at counter 1 of candidate 010 ignored; start in EVAL ignored;
      // abort during candidate 100
      mode = 2;
      s    = cyc + 1;
      expect_at(s + 10, "cand_010", eval_v(2, 3'd0));
      expect_at(s + 12, "early_sat_ignored", eval_v(3, 3'd0));
      expect_at(s + 14, "start_in_eval", eval_v(3, 3'd0));
      expect_at(s + 16, "no_restart", eval_v(4, 3'd0));
      expect_at(s + 18, "abort_in_eval", idle_v(3'd0));
      pulse_start();
      wait_until(s + 9);
      sat_manual = 1'b1;
      tick();
      sat_manual = 1'b0;
      wait_until(s + 13);
      pulse_start();
      wait_until(s + 17);
      pulse_abort();

      // start and abort together: abort wins
      s = cyc + 1;
      expect_at(s, "start_abort_same", idle_v(3'd0));
      expect_at(s + 2, "stays_idle", idle_v(3'd0));
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      wait_until(s + 3);

      // sat on the last dwell cycle of candidate 010 -> FOUND
      s = cyc + 1;
      expect_at(s + 8, "cand_010_b", eval_v(2, 3'd0));
      expect_at(s + 12, "found_010", found_v(3'b010));
      pulse_start();
      wait_until(s + 11);
      sat_manual = 1'b1;
      tick();
      sat_manual = 1'b0;
      wait_until(s + 13);

      // abort from FOUND keeps solution; start from IDLE does not clear it
      s = cyc + 1;
      expect_at(s, "abort_keeps_sol", idle_v(3'b010));
      pulse_abort();
      mode = 0;
      s    = cyc + 1;
      expect_at(s, "start_from_idle", eval_v(0, 3'b010));
      expect_at(s + 4, "mid_search", eval_v(1, 3'b010));
      expect_at(s + 5, "async_reset", idle_v(3'd0));
      pulse_start();
      wait_until(s + 5);
      reset = 1'b1;            // between edges, mid-dwell
      tick();
      tick();
      reset = 1'b0;
      expect_at(cyc + 1, "idle_after_async", idle_v(3'd0));
      tick();
      tick();
      tick();

      if (q.size() > 0) begin
         $display("FAIL unchecked_expectations: got %0d pending required 0", q.size());
         checks++;
         errors++;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
